// File: rtl/data_sync_transmitter.sv
// Source end of a 4-phase req/ack multi-bit CDC channel with a synchronized acknowledge.
// Optional one-entry pending word buffer: define DATA_SYNC_TX_PENDING_BUF_EN.
module data_sync_transmitter #(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 async_req,
  output logic [BUS_WIDTH-1:0] async_data,
  input  logic                 async_ack,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [STAGE_COUNT-1:0] sync_q;
  logic                   ack_s;
  logic                   req_q, req_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   done_q, done_d;
  logic                   accept;

  // Only this chain samples the raw acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGE_COUNT-2:0], async_ack};
  end

  assign ack_s = sync_q[STAGE_COUNT-1];

`ifdef DATA_SYNC_TX_PENDING_BUF_EN
  logic [BUS_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;

  assign in_ready = ~pend_vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign accept     = in_valid & in_ready;
  assign busy       = (state_q != IDLE);
  assign async_req  = req_q;
  assign async_data = data_q;
  assign done       = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef DATA_SYNC_TX_PENDING_BUF_EN
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef DATA_SYNC_TX_PENDING_BUF_EN
          // Chain straight into the next handshake without an IDLE cycle.
          if (pend_vld_q) begin
            data_d     = pend_q;
            req_d      = 1'b1;
            pend_vld_d = 1'b0;
            state_d    = REQ;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef DATA_SYNC_TX_PENDING_BUF_EN
    // Drain above needs pending full, which blocks accept, so no collision.
    if (accept && (state_q != IDLE)) begin
      pend_d     = in_data;
      pend_vld_d = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_data_sync_transmitter.sv
// Scoreboard bench for data_sync_transmitter with a delayed-copy acknowledge model.
module tb_data_sync_transmitter;

`ifdef DATA_SYNC_TX_PENDING_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       async_req;
  logic [7:0] async_data;
  logic       async_ack = 1'b0;
  logic       busy;
  logic       done;

  data_sync_transmitter #(.STAGE_COUNT(2), .BUS_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .async_req  (async_req),
    .async_data (async_data),
    .async_ack  (async_ack),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   pend_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Acknowledge model: 0 = async_req delayed by ack_dly negedges, 1 = tied 0, 2 = tied 1.
  int          ack_mode = 0;
  int          ack_dly = 3;
  logic [15:0] ack_pipe = '0;
  always @(negedge clk) begin
    ack_pipe = {ack_pipe[14:0], async_req};
    case (ack_mode)
      0:       async_ack = ack_pipe[ack_dly-1];
      1:       async_ack = 1'b0;
      default: async_ack = 1'b1;
    endcase
  end

  // Monitor: each request rise must present the next expected word.
  logic       prev_req = 1'b0;
  logic [7:0] prev_data = '0;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      if (async_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'(async_data), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word_data", 32'(async_data), 32'(mon_e.data));
          if (mon_e.exp_cyc >= 0) chk("req_latency", 32'(cyc), 32'(mon_e.exp_cyc));
        end
      end
      if (async_req && prev_req) chk("data_stable_during_req", 32'(async_data), 32'(prev_data));
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      prev_req  = async_req;
      prev_data = async_data;
    end else begin
      prev_req = 1'b0;
    end
  end

  // Called at a negedge; returns one negedge after the transfer edge.
  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back('{data: d, exp_cyc: (busy ? -1 : cyc + 1)});
      if (busy) pend_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy || async_req) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  int         d0, start, per, n;
  logic [7:0] w;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    chk("rst_req", 32'(async_req), 32'd0);
    chk("rst_data", 32'(async_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single word, ack = 3-cycle delayed request.
    d0 = done_cnt;
    send(8'hA5);
    wait_idle();
    chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);

    // Ack stuck low: handshake never completes.
    ack_mode = 1;
    w = 8'($urandom);
    d0 = done_cnt;
    send(w);
    repeat (30) @(negedge clk);
    chk("t2_req_held", 32'(async_req), 32'd1);
    chk("t2_busy_held", 32'(busy), 32'd1);
    chk("t2_in_ready", 32'(in_ready), BUF ? 32'd1 : 32'd0);
    chk("t2_data_held", 32'(async_data), 32'(w));
    ack_mode = 0;
    wait_idle();
    chk("t2_done_count", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset while in RELEASE.
    d0 = done_cnt;
    send(8'($urandom_range(1, 255)));
    n = 0;
    while (!(busy && !async_req) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_reached_release", 32'(busy && !async_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t3_req_async", 32'(async_req), 32'd0);
    chk("t3_data_async", 32'(async_data), 32'd0);
    chk("t3_busy_async", 32'(busy), 32'd0);
    chk("t3_done_async", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("t3_no_done_on_reset", 32'(done_cnt - d0), 32'd0);
    send(8'h5A);
    wait_idle();
    chk("t3_next_word_done", 32'(done_cnt - d0), 32'd1);

    // Ack already high before any request.
    ack_mode = 2;
    repeat (8) @(negedge clk);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_req", 32'(async_req), 32'd0);
    d0 = done_cnt;
    send(8'h3C);
    repeat (6) @(negedge clk);
    chk("t4_waiting_ack_fall", 32'(busy), 32'd1);
    ack_mode = 0;
    wait_idle();
    chk("t4_done_count", 32'(done_cnt - d0), 32'd1);

    // Back-to-back stream 0x01..0x10; cycle count follows from the ack delay.
    ack_dly = int'($urandom_range(1, 4));
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    pend_acc = 0;
    start = cyc + 1;
    for (int i = 1; i <= 16; i++) send(8'(i));
    wait_idle();
    per = BUF ? (2 * ack_dly + 4) : (2 * ack_dly + 5);
    chk("t5_done_count", 32'(done_cnt - d0), 32'd16);
    chk("t5_total_cycles", 32'(last_done_cyc - start), 32'(15 * per + 2 * ack_dly + 4));
    chk("t5_pending_accepts", 32'(pend_acc), BUF ? 32'd15 : 32'd0);

    // Random words with random gaps.
    ack_dly = int'($urandom_range(1, 5));
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom));
    end
    wait_idle();
    chk("t6_done_count", 32'(done_cnt - d0), 32'd20);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_sync_transmitter.md
# data_sync_transmitter

Source-domain end of the req/ack multi-bit CDC channel whose destination end is `data_synchronizer`. Accepts a word on a valid/ready interface, holds it stable on `async_data`, and runs a 4-phase handshake: raises `async_req`, waits for the synchronized acknowledge, drops `async_req`, then waits for the acknowledge to fall. `async_req` drives the destination's `asynchronous_data_valid`. `async_ack` is driven by the destination's `Q_pulse_generator`.

## Interface
- `STAGE_COUNT`, 2: flops in the `async_ack` synchronizer; legal range ≥2.
- `BUS_WIDTH`, 8: data width.

- `clk`  in  1  source-domain clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  BUS_WIDTH  upstream word.
- `in_ready`  out  1  block can accept a word this cycle; transfer occurs when `in_valid & in_ready`.
- `async_req`  out  1  registered request level to the destination domain.
- `async_data`  out  BUS_WIDTH  registered data; stable whenever `async_req`=1 and until ack falls.
- `async_ack`  in  1  acknowledge from the destination domain; asynchronous to `clk`.
- `busy`  out  1  handshake in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when a handshake completes.

## Operation
- `async_ack` passes through a STAGE_COUNT-flop synchronizer (reset 0) giving `ack_s`; no other logic samples raw `async_ack`.
- FSM states: IDLE, REQ, RELEASE.
  - IDLE: when a word is available (see Configuration), capture it into `async_data`, set `async_req`<=1, go to REQ.
  - REQ: hold. When `ack_s`=1, set `async_req`<=0 and go to RELEASE.
  - RELEASE: hold `async_data`. When `ack_s`=0, pulse `done` and go to IDLE.
- `async_data` changes only on the IDLE→REQ edge. Never while `async_req`=1 or `ack_s`=1.
- `async_ack` high while in IDLE is ignored. The FSM leaves IDLE only on a new word. A spurious ack already high when REQ is entered completes the handshake normally.
- Reset values: `async_req`=0, `async_data`=0, `busy`=0, `done`=0, state IDLE, sync flops 0, pending buffer empty. `in_ready`=1 after reset.
- Reset mid-handshake: all of the above takes effect immediately (asynchronous). The destination sees `async_req` fall; no `done` pulse is generated.

## Timing
- `in_ready`, `busy`: combinational from registered state only. No path from `in_valid` to `in_ready`.
- Transfer at edge N → `async_req`=1 and `async_data` valid from N+1.
- Raw `async_ack` rises before edge M → `ack_s`=1 after STAGE_COUNT edges → `async_req` falls one edge later.
- Raw ack falls → `ack_s`=0 after STAGE_COUNT edges → `done`=1 for the following cycle, state IDLE.
- Minimum cycles per word with an instant, zero-delay ack: 2·STAGE_COUNT+3 without the buffer.
- `done` is registered and asserted in the same cycle `busy` drops.

## Configuration
- Macro `DATA_SYNC_TX_PENDING_BUF_EN`.
- Undefined:
  - `in_ready` = (state==IDLE).
  - An accepted word loads `async_data` directly.
- Defined: adds a one-entry pending register.
  - `in_ready` = pending empty.
  - In IDLE with pending empty, an accepted word loads `async_data` directly, as without the macro.
  - In REQ/RELEASE, an accepted word goes to pending.
  - On the RELEASE→IDLE edge with pending full: state goes directly to REQ instead of IDLE; pending loads `async_data`; `async_req`<=1; pending empties; `done` still pulses; `busy` stays 1.
  - Simultaneous accept and drain on that edge cannot occur, because `in_ready`=0 while pending is full.

## Test plan
- Reset, then one word 0xA5 with the ack model = 3-cycle delayed copy of `async_req` → `async_req` rises the cycle after accept; `async_data`=0xA5 throughout; `done` pulses once; `in_ready` returns to 1.
- `async_ack` tied 0 → `async_req` stays 1 and `busy` stays 1 indefinitely; `in_ready`=0 (buffer off); `async_data` unchanged.
- Assert `reset` while in RELEASE → `async_req`, `async_data`, `busy`, `done` are 0 in the same cycle without waiting for `clk`; the next word handshakes normally.
- `async_ack` held 1 before any request, then a word 0x3C is accepted → FSM stays IDLE until the accept; handshake completes after ack deasserts; one `done`.
- Back-to-back stream 0x01..0x10 with `in_valid` held 1 → all 16 words appear on `async_data` in order; exactly 16 `done` pulses; `async_data` never changes while `async_req`=1.
- Same stream with `DATA_SYNC_TX_PENDING_BUF_EN` defined → second word accepted during the first handshake; REQ re-entered directly from RELEASE with no IDLE cycle; total cycles fewer than without the buffer.
